// File: rtl/clk_div_meter.sv
// Measures the half-period of a slow toggling signal in clk_in cycles and flags lock and stall.
// Define CLK_DIV_METER_DUTY_EN to add the high_time / low_time / duty_err outputs.
module clk_div_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             stalled,
`ifdef CLK_DIV_METER_DUTY_EN
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] low_time,
  output logic             duty_err,
`endif
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int               MW       = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] TO_VAL   = WIDTH'(TIMEOUT_CYC);
  localparam bit               TO_EN    = (TIMEOUT_CYC != 0);

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_prev;
  logic                   s_sync;
  logic                   sig_edge;
  logic [WIDTH-1:0]       cnt;
  logic [MW-1:0]          match_cnt;
  logic [MW-1:0]          match_nxt;
  logic                   arm;
  logic                   meas;
  logic                   timeout;
  logic                   same;
  logic                   lock_nxt;

  // Both polarities of the synchronized signal count as an edge.
  assign s_sync    = sync[SYNC_STAGES-1];
  assign sig_edge  = s_sync ^ s_prev;
  assign fsm_state = state;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sig_edge) state_nxt = ARMED;
      ARMED:   if (meas && lock_nxt) state_nxt = LOCKED;
               else if (timeout)     state_nxt = IDLE;
      LOCKED:  if (meas && !same)    state_nxt = ARMED;
               else if (timeout)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An edge always wins over a timeout landing in the same cycle.
  always_comb begin
    arm     = (state == IDLE) && sig_edge;
    meas    = (state != IDLE) && sig_edge;
    timeout = TO_EN && (state != IDLE) && !sig_edge && (cnt == TO_VAL);
    same    = (cnt == half_period);
    if (!same)                     match_nxt = MW'(1);
    else if (match_cnt >= LOCK_VAL) match_nxt = LOCK_VAL;
    else                           match_nxt = match_cnt + MW'(1);
    lock_nxt = (match_nxt == LOCK_VAL);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync        <= '0;
      s_prev      <= 1'b0;
      cnt         <= '0;
      match_cnt   <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], sig_in};
      s_prev     <= s_sync;
      meas_valid <= meas;
      if (sig_edge)        cnt <= WIDTH'(1);
      else if (cnt != '1)  cnt <= cnt + WIDTH'(1);
      if (arm) stalled <= 1'b0;
      if (meas) begin
        half_period <= cnt;
        match_cnt   <= match_nxt;
        locked      <= lock_nxt;
      end else if (timeout) begin
        stalled     <= 1'b1;
        locked      <= 1'b0;
        half_period <= '0;
        match_cnt   <= '0;
      end
    end
  end

`ifdef CLK_DIV_METER_DUTY_EN
  logic [WIDTH-1:0] high_nxt;
  logic [WIDTH-1:0] low_nxt;
  logic [WIDTH-1:0] duty_diff;

  // A falling edge closes a high phase (s_prev still holds the old level).
  always_comb begin
    high_nxt = high_time;
    low_nxt  = low_time;
    if (meas && s_prev)  high_nxt = cnt;
    if (meas && !s_prev) low_nxt  = cnt;
    duty_diff = (high_nxt > low_nxt) ? (high_nxt - low_nxt) : (low_nxt - high_nxt);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      high_time <= '0;
      low_time  <= '0;
      duty_err  <= 1'b0;
    end else if (timeout) begin
      high_time <= '0;
      low_time  <= '0;
      duty_err  <= 1'b0;
    end else begin
      high_time <= high_nxt;
      low_time  <= low_nxt;
      duty_err  <= (high_nxt != '0) && (low_nxt != '0) && (duty_diff > WIDTH'(1));
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_meter.sv
// Bench for clk_div_meter: toggle-time driven stimulus, measurement log, reference built from toggle times.
`timescale 1ns/1ps
module tb_clk_div_meter;
  localparam int W    = 16;
  localparam int SW   = 5;
  localparam int LOCK = 4;
  localparam int TO   = 64;
  localparam int LAT  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sig = 1'b0;
  logic [W-1:0]  half_period;
  logic          meas_valid;
  logic          locked;
  logic          stalled;
  logic [1:0]    fsm_state;
  logic [SW-1:0] sat_hp;
  logic          sat_mv;
  logic          sat_lk;
  logic          sat_st;
  logic [1:0]    sat_state;
`ifdef CLK_DIV_METER_DUTY_EN
  logic [W-1:0]  high_time;
  logic [W-1:0]  low_time;
  logic          duty_err;
  logic [SW-1:0] sat_ht;
  logic [SW-1:0] sat_lt;
  logic          sat_de;
`endif

  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           tog_q[$];
  int           got_cy[$];
  logic [W-1:0] got_hp[$];
  logic         got_lk[$];
  int           exp_cy[$];
  logic [W-1:0] exp_q[$];
  logic         exp_lk[$];

  clk_div_meter #(.WIDTH(W), .SYNC_STAGES(2), .LOCK_COUNT(LOCK), .TIMEOUT_CYC(TO)) dut (
    .clk_in(clk), .reset(reset), .sig_in(sig),
    .half_period(half_period), .meas_valid(meas_valid), .locked(locked), .stalled(stalled),
`ifdef CLK_DIV_METER_DUTY_EN
    .high_time(high_time), .low_time(low_time), .duty_err(duty_err),
`endif
    .fsm_state(fsm_state)
  );

  clk_div_meter #(.WIDTH(SW), .SYNC_STAGES(2), .LOCK_COUNT(LOCK), .TIMEOUT_CYC(0)) dut_sat (
    .clk_in(clk), .reset(reset), .sig_in(sig),
    .half_period(sat_hp), .meas_valid(sat_mv), .locked(sat_lk), .stalled(sat_st),
`ifdef CLK_DIV_METER_DUTY_EN
    .high_time(sat_ht), .low_time(sat_lt), .duty_err(sat_de),
`endif
    .fsm_state(sat_state)
  );

  // Clock / reset / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Measurement log
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      got_cy.push_back(cyc);
      got_hp.push_back(half_period);
      got_lk.push_back(locked);
    end
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    sig = ~sig;
    tog_q.push_back(cyc);
  endtask

  task automatic clear_log();
    tog_q.delete();
    got_cy.delete();
    got_hp.delete();
    got_lk.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sig = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(3);
    clear_log();
  endtask

  // Reference: every toggle after the arming one yields one report, LAT cycles later,
  // equal to the gap between toggles; locked when the last LOCK gaps are all equal.
  task automatic build_exp();
    exp_cy.delete();
    exp_q.delete();
    exp_lk.delete();
    for (int i = 1; i < tog_q.size(); i++) begin
      int v;
      bit lk;
      v = tog_q[i] - tog_q[i-1];
      lk = (i >= LOCK);
      for (int k = 0; k < LOCK && lk; k++)
        if (tog_q[i-k] - tog_q[i-k-1] != v) lk = 1'b0;
      exp_cy.push_back(tog_q[i] + LAT);
      exp_q.push_back(W'(v));
      exp_lk.push_back(lk);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    wait_cyc(2);
    n_chk++; if (half_period !== '0) begin n_fail++; $display("FAIL reset half_period: got %0d want 0", half_period); end
    n_chk++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset meas_valid: got %b want 0", meas_valid); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset locked: got %b want 0", locked); end
    n_chk++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL reset stalled: got %b want 0", stalled); end
    reset = 1'b0;
    wait_cyc(6);
    n_chk++; if (meas_valid !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL idle quiet: got mv=%b lk=%b want 0 0", meas_valid, locked); end
  endtask

  task automatic test_lock5();
    do_reset();
    toggle();
    repeat (6) begin wait_cyc(5); toggle(); end
    wait_cyc(LAT + 3);
    build_exp();
    n_chk++; if (got_hp.size() != exp_q.size()) begin n_fail++; $display("FAIL lock5 count: got %0d want %0d", got_hp.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_hp.size(); i++) begin
      n_chk++;
      if (got_hp[i] !== exp_q[i] || got_lk[i] !== exp_lk[i] || got_cy[i] != exp_cy[i]) begin
        n_fail++;
        $display("FAIL lock5 meas[%0d]: got hp=%0d lk=%b cyc=%0d want hp=%0d lk=%b cyc=%0d", i, got_hp[i], got_lk[i], got_cy[i], exp_q[i], exp_lk[i], exp_cy[i]);
      end
    end
  endtask

  task automatic test_unlock_relock();
    int iv[10] = '{5, 5, 5, 5, 7, 5, 5, 5, 5, 5};
    do_reset();
    toggle();
    foreach (iv[j]) begin wait_cyc(iv[j]); toggle(); end
    wait_cyc(LAT + 3);
    build_exp();
    n_chk++; if (got_hp.size() != exp_q.size()) begin n_fail++; $display("FAIL relock count: got %0d want %0d", got_hp.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_hp.size(); i++) begin
      n_chk++;
      if (got_hp[i] !== exp_q[i] || got_lk[i] !== exp_lk[i] || got_cy[i] != exp_cy[i]) begin
        n_fail++;
        $display("FAIL relock meas[%0d]: got hp=%0d lk=%b cyc=%0d want hp=%0d lk=%b cyc=%0d", i, got_hp[i], got_lk[i], got_cy[i], exp_q[i], exp_lk[i], exp_cy[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int t_last;
    int t_arm;
    do_reset();
    toggle();
    repeat (4) begin wait_cyc(10); toggle(); end
    wait_cyc(LAT + 1);
    build_exp();
    n_chk++; if (got_hp.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout pre count: got %0d want %0d", got_hp.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_hp.size(); i++) begin
      n_chk++;
      if (got_hp[i] !== exp_q[i] || got_lk[i] !== exp_lk[i] || got_cy[i] != exp_cy[i]) begin
        n_fail++;
        $display("FAIL timeout pre meas[%0d]: got hp=%0d lk=%b cyc=%0d want hp=%0d lk=%b cyc=%0d", i, got_hp[i], got_lk[i], got_cy[i], exp_q[i], exp_lk[i], exp_cy[i]);
      end
    end
    // Stall becomes visible TO cycles after the last report.
    t_last = tog_q[$];
    wait_cyc(t_last + LAT + TO - 1 - cyc);
    n_chk++; if (stalled !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL timeout early: got st=%b lk=%b want 0 1", stalled, locked); end
    wait_cyc(1);
    n_chk++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL timeout stalled: got %b want 1", stalled); end
    n_chk++; if (half_period !== '0 || locked !== 1'b0) begin n_fail++; $display("FAIL timeout clear: got hp=%0d lk=%b want 0 0", half_period, locked); end
    clear_log();
    wait_cyc(20);
    t_arm = cyc;
    toggle();
    wait_cyc(LAT + 1);
    n_chk++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL rearm stalled: got %b want 0", stalled); end
    n_chk++; if (got_hp.size() != 0) begin n_fail++; $display("FAIL rearm no meas: got %0d reports want 0", got_hp.size()); end
    wait_cyc(t_arm + 10 - cyc);
    toggle();
    wait_cyc(LAT + 1);
    n_chk++;
    if (got_hp.size() != 1) begin
      n_fail++; $display("FAIL rearm meas count: got %0d want 1", got_hp.size());
    end else if (got_hp[0] !== W'(10) || got_lk[0] !== 1'b0) begin
      n_fail++; $display("FAIL rearm meas: got hp=%0d lk=%b want 10 0", got_hp[0], got_lk[0]);
    end
  endtask

  task automatic test_fast_collision();
    do_reset();
    toggle();
    repeat (6) begin wait_cyc(1); toggle(); end
    repeat (2) begin wait_cyc(TO); toggle(); end
    wait_cyc(LAT + 1);
    build_exp();
    n_chk++; if (got_hp.size() != exp_q.size()) begin n_fail++; $display("FAIL fast count: got %0d want %0d", got_hp.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_hp.size(); i++) begin
      n_chk++;
      if (got_hp[i] !== exp_q[i] || got_lk[i] !== exp_lk[i] || got_cy[i] != exp_cy[i]) begin
        n_fail++;
        $display("FAIL fast meas[%0d]: got hp=%0d lk=%b cyc=%0d want hp=%0d lk=%b cyc=%0d", i, got_hp[i], got_lk[i], got_cy[i], exp_q[i], exp_lk[i], exp_cy[i]);
      end
    end
    n_chk++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL collision stalled: got %b want 0", stalled); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    toggle();
    repeat (5) begin wait_cyc(5); toggle(); end
    wait_cyc(5);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL midreset pre lock: got %b want 1", locked); end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (half_period !== '0 || locked !== 1'b0 || stalled !== 1'b0 || meas_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset async clear: got hp=%0d lk=%b st=%b mv=%b want all 0", half_period, locked, stalled, meas_valid);
    end
    @(negedge clk) reset = 1'b0;
    wait_cyc(3);
    clear_log();
    toggle();
    wait_cyc(6);
    toggle();
    wait_cyc(LAT + 2);
    build_exp();
    n_chk++; if (got_hp.size() != exp_q.size()) begin n_fail++; $display("FAIL midreset count: got %0d want %0d", got_hp.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_hp.size(); i++) begin
      n_chk++;
      if (got_hp[i] !== exp_q[i] || got_lk[i] !== exp_lk[i] || got_cy[i] != exp_cy[i]) begin
        n_fail++;
        $display("FAIL midreset meas[%0d]: got hp=%0d lk=%b cyc=%0d want hp=%0d lk=%b cyc=%0d", i, got_hp[i], got_lk[i], got_cy[i], exp_q[i], exp_lk[i], exp_cy[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int hold;
    int sat_max;
    int sat_exp;
    hold = 40;
    sat_max = (1 << SW) - 1;
    sat_exp = (hold > sat_max) ? sat_max : hold;
    do_reset();
    toggle();
    wait_cyc(hold);
    toggle();
    wait_cyc(LAT);
    n_chk++; if (sat_mv !== 1'b1 || sat_hp !== SW'(sat_exp)) begin n_fail++; $display("FAIL saturate: got mv=%b hp=%0d want 1 %0d", sat_mv, sat_hp, sat_exp); end
    n_chk++; if (half_period !== W'(hold)) begin n_fail++; $display("FAIL wide hold: got %0d want %0d", half_period, hold); end
    wait_cyc(TO + 10);
    n_chk++; if (stalled !== 1'b1 || sat_st !== 1'b0) begin n_fail++; $display("FAIL timeout disable: got st=%b sat_st=%b want 1 0", stalled, sat_st); end
  endtask

  task automatic test_random();
    int base;
    int v;
    do_reset();
    toggle();
    base = int'($urandom_range(2, 9));
    repeat (30) begin
      if ($urandom_range(0, 9) == 0) base = int'($urandom_range(1, 12));
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : base;
      wait_cyc(v);
      toggle();
    end
    wait_cyc(LAT + 1);
    build_exp();
    n_chk++; if (got_hp.size() != exp_q.size()) begin n_fail++; $display("FAIL random count: got %0d want %0d", got_hp.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_hp.size(); i++) begin
      n_chk++;
      if (got_hp[i] !== exp_q[i] || got_lk[i] !== exp_lk[i] || got_cy[i] != exp_cy[i]) begin
        n_fail++;
        $display("FAIL random meas[%0d]: got hp=%0d lk=%b cyc=%0d want hp=%0d lk=%b cyc=%0d", i, got_hp[i], got_lk[i], got_cy[i], exp_q[i], exp_lk[i], exp_cy[i]);
      end
    end
  endtask

`ifdef CLK_DIV_METER_DUTY_EN
  task automatic test_duty();
    int n;
    int e_hi;
    int e_lo;
    bit e_err;
    do_reset();
    toggle();
    repeat (2) begin wait_cyc(3); toggle(); wait_cyc(7); toggle(); end
    wait_cyc(LAT + 1);
    n = tog_q.size();
    e_lo = tog_q[n-1] - tog_q[n-2];
    e_hi = tog_q[n-2] - tog_q[n-3];
    e_err = (e_hi > e_lo + 1) || (e_lo > e_hi + 1);
    n_chk++;
    if (high_time !== W'(e_hi) || low_time !== W'(e_lo) || duty_err !== e_err) begin
      n_fail++; $display("FAIL duty 3/7: got hi=%0d lo=%0d err=%b want %0d %0d %b", high_time, low_time, duty_err, e_hi, e_lo, e_err);
    end
    wait_cyc(1);
    toggle();
    wait_cyc(6);
    toggle();
    wait_cyc(LAT + 1);
    n = tog_q.size();
    e_lo = tog_q[n-1] - tog_q[n-2];
    e_hi = tog_q[n-2] - tog_q[n-3];
    e_err = (e_hi > e_lo + 1) || (e_lo > e_hi + 1);
    n_chk++;
    if (high_time !== W'(e_hi) || low_time !== W'(e_lo) || duty_err !== e_err) begin
      n_fail++; $display("FAIL duty 5/6: got hi=%0d lo=%0d err=%b want %0d %0d %b", high_time, low_time, duty_err, e_hi, e_lo, e_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock5();
    test_unlock_relock();
    test_timeout();
    test_fast_collision();
    test_reset_mid();
    test_saturate();
    test_random();
`ifdef CLK_DIV_METER_DUTY_EN
    test_duty();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
